// File: rtl/cnt_seq_pkg.sv
// Shared types for the counter sequencer: FSM states and counting modes.
package cnt_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } cnt_seq_state_e;

    typedef enum logic {
        ONE_SHOT = 1'b0,
        PERIODIC = 1'b1
    } cnt_seq_mode_e;

endpackage

// File: rtl/seq_interval_counter.sv
// Count register for the sequencer. A synchronous zero takes precedence
// over increment. The enclosing FSM owns all compare and wrap decisions.
module seq_interval_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             sync_zero,
    input  logic             en,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next value: zero wins over increment; otherwise hold.
    always_comb begin
        value_d = value_q;
        if (sync_zero) begin
            value_d = '0;
        end else if (en) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/counter_sequencer.sv
// Configurable counting sequencer: IDLE/RUN/HOLD/DONE FSM driving a
// 0..limit counter in one-shot or periodic mode, with a one-cycle tick
// after every terminal advance.
//
// Optional build macro CNT_SEQ_PRESCALE_EN adds the cfg_prescale input;
// RUN advances then occur once every cfg_prescale+1 clocks. Without it the
// prescale value is a constant zero, so the prescaler logic collapses and
// every RUN cycle advances.
//
// Config handshake: a transfer occurs on a cycle where cfg_valid and
// cfg_ready are both high. cfg_ready is high only in IDLE or DONE and is
// withheld while stop is asserted, because stop outranks configuration.
module counter_sequencer
    import cnt_seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PRE_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [WIDTH-1:0]     cfg_limit,
    input  logic                 cfg_mode,
`ifdef CNT_SEQ_PRESCALE_EN
    input  logic [PRE_WIDTH-1:0] cfg_prescale,
`endif
    input  logic                 start,
    input  logic                 stop,
    input  logic                 pause,
    output logic [WIDTH-1:0]     count,
    output logic                 tick,
    output logic                 busy,
    output logic                 done,
    output cnt_seq_state_e       dbg_state
);

    cnt_seq_state_e        state_q, state_d;
    cnt_seq_mode_e         mode_q, mode_d;
    logic [WIDTH-1:0]      limit_q, limit_d;
    logic [PRE_WIDTH-1:0]  prescale_q, prescale_d;
    logic [PRE_WIDTH-1:0]  pre_q, pre_d;
    logic                  tick_q, tick_d;
    logic                  cnt_zero;
    logic                  cnt_en;
    logic                  cfg_hs;
    logic                  presc_hit;
    logic [WIDTH-1:0]      count_w;

    seq_interval_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk       (clk),
        .clear     (clear),
        .sync_zero (cnt_zero),
        .en        (cnt_en),
        .value     (count_w)
    );

    assign cfg_ready = ((state_q == IDLE) || (state_q == DONE)) && !stop;
    assign cfg_hs    = cfg_valid && cfg_ready;
    assign presc_hit = (pre_q == prescale_q);

    // Next state and counter controls, evaluated in priority order:
    // stop, config handshake, start, pause, advance.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        limit_d    = limit_q;
        prescale_d = prescale_q;
        pre_d      = pre_q;
        tick_d     = 1'b0;
        cnt_zero   = 1'b0;
        cnt_en     = 1'b0;

        if (stop) begin
            state_d  = IDLE;
            cnt_zero = 1'b1;
            pre_d    = '0;
        end else if (cfg_hs) begin
            limit_d  = cfg_limit;
            mode_d   = cnt_seq_mode_e'(cfg_mode);
`ifdef CNT_SEQ_PRESCALE_EN
            prescale_d = cfg_prescale;
`endif
            state_d  = IDLE;
            cnt_zero = 1'b1;
            pre_d    = '0;
        end else if (start && (limit_q != '0) &&
                     ((state_q == IDLE) || (state_q == DONE))) begin
            state_d  = RUN;
            cnt_zero = 1'b1;
            pre_d    = '0;
        end else if ((state_q == RUN) && pause) begin
            // Counter and prescaler simply hold while in HOLD.
            state_d = HOLD;
        end else if (state_q == HOLD) begin
            if (!pause) begin
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            if (!presc_hit) begin
                pre_d = pre_q + PRE_WIDTH'(1);
            end else begin
                pre_d = '0;
                if (count_w < limit_q) begin
                    cnt_en = 1'b1;
                end else begin
                    // Terminal advance: count never exceeds limit_q.
                    tick_d = 1'b1;
                    if (mode_q == PERIODIC) begin
                        cnt_zero = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
        end
    end

    // FSM, configuration and tick registers with asynchronous clear.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q    <= IDLE;
            mode_q     <= ONE_SHOT;
            limit_q    <= '0;
            prescale_q <= '0;
            pre_q      <= '0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            limit_q    <= limit_d;
            prescale_q <= prescale_d;
            pre_q      <= pre_d;
            tick_q     <= tick_d;
        end
    end

    assign count     = count_w;
    assign tick      = tick_q;
    assign busy      = (state_q == RUN) || (state_q == HOLD);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural model through a queue.
module tb_counter_sequencer;
    import cnt_seq_pkg::*;

    localparam int WIDTH     = 8;
    localparam int PRE_WIDTH = 4;
    localparam int EW        = 2 + 3 + WIDTH;

    logic                 clk = 1'b0;
    logic                 clear;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [WIDTH-1:0]     cfg_limit;
    logic                 cfg_mode;
    logic [PRE_WIDTH-1:0] cfg_prescale;
    logic                 start;
    logic                 stop;
    logic                 pause;
    logic [WIDTH-1:0]     count;
    logic                 tick;
    logic                 busy;
    logic                 done;
    cnt_seq_state_e       dbg_state;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    counter_sequencer #(
        .WIDTH     (WIDTH),
        .PRE_WIDTH (PRE_WIDTH)
    ) dut (
        .clk          (clk),
        .clear        (clear),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_limit    (cfg_limit),
        .cfg_mode     (cfg_mode),
`ifdef CNT_SEQ_PRESCALE_EN
        .cfg_prescale (cfg_prescale),
`endif
        .start        (start),
        .stop         (stop),
        .pause        (pause),
        .count        (count),
        .tick         (tick),
        .busy         (busy),
        .done         (done),
        .dbg_state    (dbg_state)
    );

    // ---------------- reference model ----------------
    cnt_seq_state_e m_state;
    int             m_count;
    int             m_limit;
    int             m_prescale;
    int             m_pre;
    bit             m_periodic;
    bit             m_tick;

    logic [EW-1:0] exp_q[$];
    int            checks = 0;
    int            passes = 0;

    task automatic check_val(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] pack_exp(input cnt_seq_state_e st,
                                               input bit tk, input int cnt);
        logic is_done;
        logic is_busy;
        is_done = (st == DONE);
        is_busy = (st == RUN) || (st == HOLD);
        return {st, is_done, is_busy, tk, WIDTH'(cnt)};
    endfunction

    task automatic model_reset();
        m_state    = IDLE;
        m_count    = 0;
        m_limit    = 0;
        m_prescale = 0;
        m_pre      = 0;
        m_periodic = 1'b0;
        m_tick     = 1'b0;
    endtask

    // One clock of the specified behaviour, in priority order.
    task automatic model_step(input bit cv, input int lim, input bit md,
                              input int psc, input bit st, input bit sp,
                              input bit ps);
        bit idle_or_done;
        idle_or_done = (m_state == IDLE) || (m_state == DONE);
        m_tick = 1'b0;
        if (sp) begin
            m_state = IDLE;
            m_count = 0;
            m_pre   = 0;
        end else if (cv && idle_or_done) begin
            m_limit    = lim % 256;
            m_periodic = md;
`ifdef CNT_SEQ_PRESCALE_EN
            m_prescale = psc;
`else
            m_prescale = 0;
`endif
            m_state = IDLE;
            m_count = 0;
            m_pre   = 0;
        end else if (st && m_limit != 0 && idle_or_done) begin
            m_state = RUN;
            m_count = 0;
            m_pre   = 0;
        end else if (m_state == RUN && ps) begin
            m_state = HOLD;
        end else if (m_state == HOLD) begin
            if (!ps) m_state = RUN;
        end else if (m_state == RUN) begin
            if (m_pre < m_prescale) begin
                m_pre++;
            end else begin
                m_pre = 0;
                if (m_count < m_limit) begin
                    m_count++;
                end else begin
                    m_tick = 1'b1;
                    if (m_periodic) m_count = 0;
                    else m_state = DONE;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit cv, input int lim, input bit md,
                         input int psc, input bit st, input bit sp,
                         input bit ps);
        bit exp_ready;
        @(negedge clk);
        cfg_valid    = cv;
        cfg_limit    = WIDTH'(lim);
        cfg_mode     = md;
        cfg_prescale = PRE_WIDTH'(psc);
        start        = st;
        stop         = sp;
        pause        = ps;
        #1;
        exp_ready = ((m_state == IDLE) || (m_state == DONE)) && !sp;
        check_val("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
        model_step(cv, lim, md, psc, st, sp, ps);
        exp_q.push_back(pack_exp(m_state, m_tick, m_count));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic configure(input int lim, input bit md, input int psc);
        drive(1, lim, md, psc, 0, 0, 0);
    endtask

    task automatic check_reset_outputs();
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_tick", 32'(tick), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check_val("rst_state", 32'(dbg_state), 32'(IDLE));
    endtask

    // Asynchronous clear asserted between edges, held across one edge.
    task automatic do_clear();
        @(negedge clk);
        clear     = 1'b1;
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        pause     = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        exp_q.push_back(pack_exp(IDLE, 1'b0, 0));
        @(negedge clk);
        clear = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("state", 32'(dbg_state), 32'(e[EW-1 -: 2]));
                check_val("done", 32'(done), 32'(e[WIDTH+2]));
                check_val("busy", 32'(busy), 32'(e[WIDTH+1]));
                check_val("tick", 32'(tick), 32'(e[WIDTH]));
                check_val("count", 32'(count), 32'(e[WIDTH-1:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit rp;
        clear        = 1'b1;
        cfg_valid    = 1'b0;
        cfg_limit    = '0;
        cfg_mode     = 1'b0;
        cfg_prescale = '0;
        start        = 1'b0;
        stop         = 1'b0;
        pause        = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        clear = 1'b0;

        // One-shot limit 3: 0,1,2,3 then DONE with a single tick.
        configure(3, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(6);
        // Restart from DONE, then stop while DONE.
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(5);
        drive(0, 0, 0, 0, 0, 1, 0);
        idle(1);

        // Periodic limit 2: wraps with a tick per period, stays busy.
        configure(2, 1, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(10);
        drive(0, 0, 0, 0, 0, 1, 0);

        // Limit 5 with a three-cycle pause at count 2.
        configure(5, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(2);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 1);
        idle(6);

        // Stop coinciding with the terminal advance: no tick.
        configure(3, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(3);
        drive(0, 0, 0, 0, 0, 1, 0);
        idle(2);

        // Config offered mid-run is refused; limit remains 3.
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(1, 7, 1, 0, 0, 0, 0);
        idle(6);

        // Limit 0 makes start a no-op; start ignored while running.
        configure(0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(2);
        configure(4, 1, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(2);
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(2);

        // Clear mid-run at count 4; following start needs a new config.
        configure(6, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(4);
        do_clear();
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(2);

        // Prescale 2, limit 1 (only affects the prescaled build).
        configure(1, 0, 2);
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(8);

        // Large limit, periodic, then stopped before terminal count.
        configure(255, 1, 1);
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(12);
        drive(0, 0, 0, 0, 0, 1, 0);

        // Randomized traffic.
        rp = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_clear();
                rp = 1'b0;
            end else begin
                if ($urandom_range(0, 5) == 0) rp = ~rp;
                drive(($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                                   : int'($urandom_range(0, 6)),
                      1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)),
                      ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 24) == 0),
                      rp);
            end
        end

        idle(2);
        repeat (2) @(negedge clk);
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter: WIDTH, default 8, counter/limit width in bits (SHALL be >= 2).
REQ-002 Parameter: PRE_WIDTH, default 4, prescaler width in bits (used only under CNT_SEQ_PRESCALE_EN).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 clear  input  1  asynchronous, active-high reset.
REQ-005 cfg_valid  input  1  configuration offer.
REQ-006 cfg_ready  output  1  configuration accepted this cycle when high together with cfg_valid.
REQ-007 cfg_limit  input  WIDTH  terminal count, latched on handshake.
REQ-008 cfg_mode  input  1  0 = one-shot, 1 = periodic, latched on handshake.
REQ-009 start  input  1  begin or restart counting.
REQ-010 stop  input  1  abort and return to idle.
REQ-011 pause  input  1  level; freezes counting while high.
REQ-012 count  output  WIDTH  current count value.
REQ-013 tick  output  1  registered one-cycle pulse per completed period.
REQ-014 busy  output  1  high in RUN or HOLD.
REQ-015 done  output  1  high in DONE.

Function
REQ-016 FSM states SHALL be IDLE, RUN, HOLD and DONE.
REQ-017 cfg_ready SHALL be high only in IDLE or DONE. A handshake SHALL latch limit and mode, clear count to 0 and go to IDLE.
REQ-018 start in IDLE or DONE with latched limit != 0 -> RUN next cycle, count = 0. start with limit == 0, or in RUN/HOLD, SHALL be ignored.
REQ-019 RUN advance: if count < limit, count increments by 1. If count == limit, periodic wraps count to 0 and stays in RUN; one-shot holds count at limit and goes to DONE.
REQ-020 tick SHALL be high for exactly the one cycle after each count == limit advance. A period therefore spans limit+1 advances.
REQ-021 pause high in RUN -> HOLD with count frozen; pause low in HOLD -> RUN, resuming from the frozen count. pause is ignored in IDLE and DONE.
REQ-022 stop in RUN, HOLD or DONE -> IDLE next cycle, count = 0, no tick.
REQ-023 Same-cycle priority SHALL be: stop > cfg handshake > start > pause > advance. stop coinciding with the terminal advance SHALL suppress tick.
REQ-024 count SHALL never exceed the latched limit. Arithmetic is WIDTH-bit unsigned, with no carry out.

Reset
REQ-025 While clear is high: state = IDLE, count = 0, tick = 0, busy = 0, done = 0, cfg_ready = 1, latched limit = 0, mode = one-shot (and prescale = 0 when enabled).
REQ-026 clear asserted mid-RUN SHALL abort immediately and asynchronously, with no tick. The first start after clear releases SHALL need a fresh configuration, since limit = 0.

Configuration
REQ-027 Macro CNT_SEQ_PRESCALE_EN. When defined, the module adds input cfg_prescale [PRE_WIDTH-1:0], latched on handshake. A RUN advance then occurs once every cfg_prescale+1 clk cycles.
REQ-028 With the macro, the prescaler SHALL be cleared on start, stop and handshake, and frozen in HOLD. tick SHALL stay one clk cycle wide.
REQ-029 Without the macro, cfg_prescale is absent and an advance occurs every RUN cycle.

Structure
REQ-030 Package cnt_seq_pkg SHALL hold the state enum (IDLE/RUN/HOLD/DONE) and the mode enum (ONE_SHOT/PERIODIC).
REQ-031 The count register SHALL be the sub-module seq_interval_counter: WIDTH parameter, inputs clk, clear, sync_zero and en, output value. The FSM and compare logic SHALL stay in counter_sequencer.

Verification
REQ-032 WIDTH=8, cfg limit=3 one-shot, start -> count 0,1,2,3 over 4 cycles; tick one cycle; done=1; count holds 3.
REQ-033 limit=2 periodic, run 9 cycles -> count 0,1,2,0,1,2,0,1,2; tick after each wrap; busy stays 1.
REQ-034 limit=5, pause at count=2 for 3 cycles -> count held 2, busy=1, state HOLD; resumes 3,4,5.
REQ-035 limit=3 one-shot, stop in the same cycle as the count==3 advance -> no tick; count=0 and IDLE next cycle. cfg_valid during RUN -> cfg_ready=0 and limit unchanged.
REQ-036 clear pulsed mid-RUN at count=4 -> all outputs at reset values. Subsequent start without a new cfg is ignored (limit=0).
REQ-037 With CNT_SEQ_PRESCALE_EN, prescale=2, limit=1 -> count changes every 3 cycles; tick 6 cycles after start.
